// File: rtl/gb_bus_write_sync_if.sv
// Bus bundle between the Game Boy cartridge edge and the mapper write-event front end.
// The slave side is the synchronizer; the master side drives the raw bus and consumes events.
interface gb_bus_write_sync_if;
  logic [3:0] GB_A_HI;
  logic [7:0] GB_D;
  logic       nGB_WR;
  logic       cfg_unlock;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       we_ram_en;
  logic       we_rom_lo;
  logic       we_rom_hi;
  logic       we_ram_bank;
  logic       we_game_en;
  logic       we_game_sel;
  logic       we_rst_req;
  logic [7:0] drop_cnt;

  modport slave (
    input  GB_A_HI, GB_D, nGB_WR, cfg_unlock,
    output wr_valid, wr_addr, wr_data, we_ram_en, we_rom_lo, we_rom_hi,
           we_ram_bank, we_game_en, we_game_sel, we_rst_req, drop_cnt
  );

  modport master (
    output GB_A_HI, GB_D, nGB_WR, cfg_unlock,
    input  wr_valid, wr_addr, wr_data, we_ram_en, we_rom_lo, we_rom_hi,
           we_ram_bank, we_game_en, we_game_sel, we_rst_req, drop_cnt
  );
endinterface

// File: rtl/gb_bus_write_sync.sv
// Synchronizes the cartridge write strobe, address nibble and data into the oscillator domain
// and turns each valid host write into one decoded single-cycle write event.
module gb_bus_write_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 3,
  parameter int MAX_LOW     = 200
) (
  input logic                osc_sig,
  input logic                nRST,
  gb_bus_write_sync_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, ARMED, STUCK} state_t;

  logic [SYNC_STAGES-1:0] wr_sync_reg;
  logic [3:0]             a_sync_reg [SYNC_STAGES];
  logic [7:0]             d_sync_reg [SYNC_STAGES];
  logic [SYNC_STAGES:0]   flush_reg;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] cap_a_reg;
  logic [7:0] cap_d_reg;
  logic       cap_en, fire, drop;

  logic       wr_valid_reg;
  logic [3:0] wr_addr_reg;
  logic [7:0] wr_data_reg;
  logic [6:0] we_reg, we_dec;
  logic [7:0] drop_cnt_reg;

  logic       wr_s, sync_ready, sync_first;
  logic [3:0] a_s;
  logic [7:0] d_s;

  assign wr_s = wr_sync_reg[SYNC_STAGES-1];
  assign a_s  = a_sync_reg[SYNC_STAGES-1];
  assign d_s  = d_sync_reg[SYNC_STAGES-1];

  // flush_reg marks when wr_s first carries a real bus sample after reset, so a strobe
  // that was already low through reset is parked in STUCK instead of being accepted.
  assign sync_ready = flush_reg[SYNC_STAGES-1];
  assign sync_first = sync_ready & ~flush_reg[SYNC_STAGES];

  always_ff @(posedge osc_sig or negedge nRST) begin
    if (!nRST) begin
      wr_sync_reg <= '1;
      flush_reg   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_sync_reg[i] <= '0;
        d_sync_reg[i] <= '0;
      end
    end else begin
      wr_sync_reg   <= {wr_sync_reg[SYNC_STAGES-2:0], bus.nGB_WR};
      flush_reg     <= {flush_reg[SYNC_STAGES-1:0], 1'b1};
      a_sync_reg[0] <= bus.GB_A_HI;
      d_sync_reg[0] <= bus.GB_D;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_sync_reg[i] <= a_sync_reg[i-1];
        d_sync_reg[i] <= d_sync_reg[i-1];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cap_en     = 1'b0;
    fire       = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync_ready && !wr_s) begin
          if (sync_first) begin
            state_next = STUCK;
          end else begin
            cnt_next = 8'd1;
            if (MIN_LOW <= 1) begin
              cap_en     = 1'b1;
              state_next = ARMED;
            end else begin
              state_next = LOW;
            end
          end
        end
      end
      LOW: begin
        if (wr_s) begin
          state_next = IDLE;
          drop       = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_next == 8'(MIN_LOW)) begin
            cap_en     = 1'b1;
            state_next = ARMED;
          end
        end
      end
      ARMED: begin
        if (wr_s) begin
          state_next = IDLE;
          fire       = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_next == 8'(MAX_LOW)) begin
            state_next = STUCK;
            drop       = 1'b1;
          end
        end
      end
      STUCK: begin
        if (wr_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit order: ram_en, rom_lo, rom_hi, ram_bank, game_en, game_sel, rst_req.
  always_comb begin
    we_dec    = '0;
    we_dec[6] = (cap_a_reg == 4'h0) || (cap_a_reg == 4'h1);
    we_dec[5] = (cap_a_reg == 4'h2);
    we_dec[4] = (cap_a_reg == 4'h3);
    we_dec[3] = (cap_a_reg == 4'h4) || (cap_a_reg == 4'h5);
    we_dec[2] = (cap_a_reg == 4'hA) && bus.cfg_unlock;
    we_dec[1] = (cap_a_reg == 4'hB) && bus.cfg_unlock;
    we_dec[0] = (cap_a_reg == 4'h4) && bus.cfg_unlock;
  end

  always_ff @(posedge osc_sig or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cap_a_reg    <= '0;
      cap_d_reg    <= '0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      we_reg       <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wr_valid_reg <= fire;
      we_reg       <= fire ? we_dec : 7'd0;
      if (cap_en) begin
        cap_a_reg <= a_s;
        cap_d_reg <= d_s;
      end
      if (fire) begin
        wr_addr_reg <= cap_a_reg;
        wr_data_reg <= cap_d_reg;
      end
      if (drop && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign bus.wr_valid    = wr_valid_reg;
  assign bus.wr_addr     = wr_addr_reg;
  assign bus.wr_data     = wr_data_reg;
  assign bus.we_ram_en   = we_reg[6];
  assign bus.we_rom_lo   = we_reg[5];
  assign bus.we_rom_hi   = we_reg[4];
  assign bus.we_ram_bank = we_reg[3];
  assign bus.we_game_en  = we_reg[2];
  assign bus.we_game_sel = we_reg[1];
  assign bus.we_rst_req  = we_reg[0];
  assign bus.drop_cnt    = drop_cnt_reg;

endmodule

// File: doc/gb_bus_write_sync.md
Name: gb_bus_write_sync

Overview:
- Front-end stage directly upstream of the MBC5 mapper registers.
- Brings the asynchronous cartridge write strobe (nGB_WR), GB_A[15:12] and GB_D[7:0] into the internal oscillator domain, rejecting runt and stuck pulses.
- Emits exactly one single-cycle, decoded write event per valid host write. The mapper updates its bank and enable registers from these events instead of clocking on raw bus edges.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizer; the same depth is applied to nGB_WR, GB_A[15:12] and GB_D. Legal range 2..4.
- MIN_LOW, 3, synchronized low cycles required before a write is accepted and its address/data captured. Legal range 1..MAX_LOW-1.
- MAX_LOW, 200, synchronized low cycles after which the strobe is treated as stuck and the write is dropped. Legal range MIN_LOW+1..255.

Ports:
- osc_sig  in  1  internal oscillator clock; all logic on its rising edge.
- nRST  in  1  asynchronous active-low reset.
- GB_A_HI  in  4  GB_A[15:12], asynchronous.
- GB_D  in  8  cartridge data bus, asynchronous.
- nGB_WR  in  1  host write strobe, active low, asynchronous.
- cfg_unlock  in  1  mapper's ram_bank[4]; qualifies the config strobes.
- wr_valid  out  1  one-cycle pulse marking an accepted write.
- wr_addr  out  4  captured A[15:12]; held until the next accepted write.
- wr_data  out  8  captured D[7:0]; held until the next accepted write.
- we_ram_en  out  1  wr_valid and address nibble 0x0 or 0x1.
- we_rom_lo  out  1  wr_valid and nibble 0x2.
- we_rom_hi  out  1  wr_valid and nibble 0x3.
- we_ram_bank  out  1  wr_valid and nibble 0x4 or 0x5.
- we_game_en  out  1  wr_valid, nibble 0xA and cfg_unlock.
- we_game_sel  out  1  wr_valid, nibble 0xB and cfg_unlock.
- we_rst_req  out  1  wr_valid, nibble 0x4 and cfg_unlock. Asserted together with we_ram_bank.
- drop_cnt  out  8  saturating count of rejected strobes.

Behaviour:
- Reset, asynchronous while nRST=0:
  - nGB_WR synchronizer chain presets to 1; address and data chains clear to 0.
  - FSM goes to IDLE and the low counter clears to 0.
  - wr_valid, wr_addr, wr_data, all we_* outputs and drop_cnt clear to 0.
- Reset asserted mid-write aborts the write with no pulse and no drop count. After release, a strobe already low is not accepted: the FSM waits in STUCK for a synchronized 1 (release enters STUCK if wr_s=0).
- Synchronization:
  - wr_s, a_s and d_s are the outputs of the last synchronizer stage.
  - Address and data pass through the same depth as the strobe, so they stay cycle-aligned with wr_s.
- FSM, evaluated each clock:
  - IDLE: wr_s=0 -> LOW with cnt=1.
  - LOW: wr_s=1 -> IDLE and drop_cnt+1 (runt pulse). Otherwise cnt+1. When cnt reaches MIN_LOW, latch a_s/d_s into a capture register and go to ARMED.
  - ARMED: wr_s=1 -> IDLE and fire the write event. Otherwise cnt+1. If cnt reaches MAX_LOW -> STUCK and drop_cnt+1.
  - STUCK: stay until wr_s=1, then go to IDLE. No event fires.
- Capture timing: address/data are sampled at the MIN_LOW-th synchronized low cycle, i.e. mid-pulse. Bus transitions at the strobe edges are never captured.
- Event output, registered:
  - In the cycle after ARMED sees wr_s=1, wr_valid=1 for exactly one cycle.
  - wr_addr/wr_data update from the capture register in that same cycle.
  - The we_* outputs are decoded from the captured address and the cfg_unlock value sampled in the ARMED->IDLE cycle, and are registered alongside wr_valid.
- Latency: wr_valid rises SYNC_STAGES+1 clocks (+0/+1 for asynchronous phase) after nGB_WR rises.
- Back-to-back writes: a new falling edge seen in the same cycle the event fires is handled normally from IDLE on the next cycle. No write is lost if high time ≥ 1 clock after synchronization.
- drop_cnt saturates at 255 and does not wrap.
- Strobes that never go low produce nothing.
- Address nibbles 0x6–0x9 and 0xC–0xF produce wr_valid with all we_* = 0.
- Nibbles 0xA/0xB with cfg_unlock=0 also produce wr_valid with all we_* = 0. These are ordinary RAM writes that the mapper ignores.

Test Plan:
- Reset release, then nGB_WR low 10 clocks, A=0x2, D=0x05 -> one wr_valid pulse 3–4 clocks after the rising edge; wr_addr=0x2, wr_data=0x05, we_rom_lo=1, all other we_*=0, drop_cnt=0.
- nGB_WR low for 2 clocks (MIN_LOW=3) -> no wr_valid; drop_cnt=1. Repeat 300 times -> drop_cnt=255.
- A=0xA, D=0x01, cfg_unlock=1 -> we_game_en=1. Same write with cfg_unlock=0 -> wr_valid=1, we_game_en=0.
- A=0x4, D=0x10, cfg_unlock=1 -> we_ram_bank=1 and we_rst_req=1 in the same cycle.
- nGB_WR held low 250 clocks -> no event, drop_cnt+1. A following normal write (A=0x3, D=0x01) -> we_rom_hi=1.
- Data changes from 0x55 to 0xAA one clock before the nGB_WR rising edge -> wr_data=0x55. nRST pulsed low mid-pulse -> no event, all outputs 0.
